// File: rtl/fmul_share_arbiter_pkg.sv
// Shared definitions for the multiplier-sharing arbiter slice.
// Holds the float word width, the float word type, and the helper that
// sizes requester-index fields from a requester count.
package fmul_pkg;

  localparam int FLOAT_W = 32;

  typedef logic [FLOAT_W-1:0] float_t;

  // Width of an index able to name n requesters. Never narrower than one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fmul_share_arbiter_if.sv
// Handshake bundle between requesters / consumer and the shared multiplier.
//   req_valid/req_ready : per-requester operand handshake
//   req_a/req_b         : packed operands, requester i at [32i+31:32i]
//   rsp_valid/rsp_ready : shared product handshake
//   rsp_z/rsp_id        : product word and owning requester index
// slave  : the arbiter side
// master : the requester/consumer side
interface fmul_share_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = fmul_pkg::id_width(NUM_REQ)
);
  import fmul_pkg::*;

  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*FLOAT_W-1:0] req_a;
  logic [NUM_REQ*FLOAT_W-1:0] req_b;
  logic                       rsp_valid;
  logic                       rsp_ready;
  float_t                     rsp_z;
  logic [ID_W-1:0]            rsp_id;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_z, rsp_id
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_z, rsp_id
  );
endinterface

// File: rtl/comb_multiplier.sv
// Purely combinational single-precision multiplier, round-to-nearest-even.
//   a, b     : IEEE-754 operands
//   output_z : IEEE-754 product
// Subnormal operands are treated as zero and results below the normal
// range flush to signed zero; overflow saturates to signed infinity.
module comb_multiplier
  import fmul_pkg::*;
(
  input  float_t a,
  input  float_t b,
  output float_t output_z
);

  logic        sign_z;
  logic [7:0]  exp_a, exp_b;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [47:0] prod;
  logic        norm;
  logic [23:0] keep;
  logic        guard, sticky, round_up;
  logic [24:0] rounded;
  logic [9:0]  exp_tmp;

  always_comb begin
    sign_z = a[31] ^ b[31];
    exp_a  = a[30:23];
    exp_b  = b[30:23];
    a_zero = (exp_a == 8'd0);
    b_zero = (exp_b == 8'd0);
    a_inf  = (exp_a == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (exp_b == 8'hFF) && (b[22:0] == 23'd0);
    a_nan  = (exp_a == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (exp_b == 8'hFF) && (b[22:0] != 23'd0);

    prod = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    norm = prod[47];

    // Keep the 24 significant bits; the next bit is guard, the rest sticky.
    if (norm) begin
      keep   = prod[47:24];
      guard  = prod[23];
      sticky = |prod[22:0];
    end else begin
      keep   = prod[46:23];
      guard  = prod[22];
      sticky = |prod[21:0];
    end
    round_up = guard & (sticky | keep[0]);
    rounded  = {1'b0, keep} + {24'd0, round_up};

    // Biased sum still carries one extra bias of 127 at this point.
    exp_tmp = {2'b00, exp_a} + {2'b00, exp_b} + {9'd0, norm} + {9'd0, rounded[24]};

    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      output_z = 32'h7FC00000;
    end else if (a_inf || b_inf) begin
      output_z = {sign_z, 8'hFF, 23'd0};
    end else if (a_zero || b_zero || (exp_tmp <= 10'd127)) begin
      output_z = {sign_z, 31'd0};
    end else if (exp_tmp >= 10'd382) begin
      output_z = {sign_z, 8'hFF, 23'd0};
    end else begin
      output_z = {sign_z, 8'(exp_tmp - 10'd127), rounded[22:0]};
    end
  end

endmodule

// File: rtl/fmul_share_arbiter_rr.sv
// Round-robin arbiter with a registered "last granted" pointer.
//   clk, rst  : clock and synchronous active-high reset
//   req       : request vector
//   advance   : grant was taken this cycle; move the pointer to it
//   grant     : one-hot grant (combinational)
//   grant_idx : index of the granted requester
module rr_arbiter
  import fmul_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = id_width(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] last;
  logic             found;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int k = 1; k <= N; k++) begin
      logic [IDX_W-1:0] cand;
      cand = IDX_W'((int'(last) + k) % N);
      if (!found && req[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    if (found) grant[grant_idx] = 1'b1;
  end

  // Reset to the top index so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= IDX_W'(N - 1);
    end else if (advance) begin
      last <= grant_idx;
    end
  end

endmodule

// File: rtl/fmul_share_arbiter.sv
// Shares one combinational multiplier between NUM_REQ requesters.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of the request/response bundle
// Two register stages wrap the multiplier: OP (operands + tag) feeds it,
// RSP captures the product. Each stage moves when its successor can take it.
module fmul_share_arbiter
  import fmul_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input logic                  clk,
  input logic                  rst,
  fmul_share_arbiter_if.slave  bus
);

  logic               rsp_adv, op_adv, accept;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  float_t             a_arr [NUM_REQ];
  float_t             b_arr [NUM_REQ];

  logic               op_valid;
  float_t             op_a, op_b;
  logic [ID_W-1:0]    op_id;
  float_t             mul_z;

  logic               rsp_valid;
  float_t             rsp_z;
  logic [ID_W-1:0]    rsp_id;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      a_arr[i] = bus.req_a[i*FLOAT_W +: FLOAT_W];
      b_arr[i] = bus.req_b[i*FLOAT_W +: FLOAT_W];
    end
  end

  rr_arbiter #(.N(NUM_REQ), .IDX_W(ID_W)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (bus.req_valid),
    .advance   (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Ready is withheld during reset so nothing is accepted into a stage
  // that is being cleared.
  always_comb begin
    rsp_adv       = !rsp_valid || bus.rsp_ready;
    op_adv        = !op_valid || rsp_adv;
    bus.req_ready = (op_adv && !rst) ? grant : '0;
    accept        = |(bus.req_valid & bus.req_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_valid <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      op_id    <= '0;
    end else if (op_adv) begin
      op_valid <= accept;
      if (accept) begin
        op_a  <= a_arr[grant_idx];
        op_b  <= b_arr[grant_idx];
        op_id <= grant_idx;
      end
    end
  end

  comb_multiplier u_mul (
    .a        (op_a),
    .b        (op_b),
    .output_z (mul_z)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_z     <= '0;
      rsp_id    <= '0;
    end else if (rsp_adv) begin
      rsp_valid <= op_valid;
      rsp_z     <= mul_z;
      rsp_id    <= op_id;
    end
  end

  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_z     = rsp_z;
  assign bus.rsp_id    = rsp_id;

endmodule

// File: tb/tb_fmul_share_arbiter.sv
// Self-checking bench for fmul_share_arbiter: random and directed operand
// traffic, a scoreboard queue of expected products, and a separate monitor
// that checks every response handshake against it.
module tb_fmul_share_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;

  typedef struct {
    logic [31:0]   z;
    logic [IW-1:0] id;
    int            acc;
    bit            lat;
  } exp_t;

  logic clk;
  logic rst;

  fmul_share_arbiter_if #(.NUM_REQ(N), .ID_W(IW)) bus ();

  fmul_share_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  exp_t        sb[$];
  int          n_acc = 0;
  int          n_cons = 0;
  int          model_last = N - 1;
  bit          in_reset = 1;
  bit          pend[N];
  logic [31:0] pa[N], pb[N], pz[N];
  bit          stall_hold = 0;
  logic [31:0] held_z;
  logic [IW-1:0] held_id;
  bit          head_seen = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Reference product for normal operands whose product stays normal:
  // exact integer product of the significands, then round-half-even.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint unsigned ma, mb, prod, scale, q, r, half;
    int e;
    ma = {41'd0, 1'b1, a[22:0]};
    mb = {41'd0, 1'b1, b[22:0]};
    prod = ma * mb;
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (prod >= (64'd1 << 47)) begin
      scale = 64'd1 << 24;
      e++;
    end else begin
      scale = 64'd1 << 23;
    end
    q = prod / scale;
    r = prod % scale;
    half = scale / 2;
    if (r > half || (r == half && (q % 2) == 1)) q++;
    if (q == (64'd1 << 24)) begin
      q = q / 2;
      e++;
    end
    return {a[31] ^ b[31], e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rand_float();
    logic [7:0] ex;
    ex = 8'($urandom_range(154, 100));
    return {1'($urandom_range(1)), ex, 23'($urandom)};
  endfunction

  task automatic driveBus();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i] = pend[i];
      bus.req_a[i*32 +: 32] = pa[i];
      bus.req_b[i*32 +: 32] = pb[i];
    end
  endtask

  // Compares the request-side handshake with a round-robin / occupancy
  // model and records any accept into the scoreboard.
  task automatic checkOutput();
    int inflight, g;
    logic [N-1:0] exp_ready;
    bit any;
    inflight = n_acc - n_cons;
    any = |bus.req_valid;
    g = 0;
    for (int k = N; k >= 1; k--) begin
      if (bus.req_valid[(model_last + k) % N]) g = (model_last + k) % N;
    end
    exp_ready = '0;
    if (any && !(inflight >= 2 && !bus.rsp_ready)) exp_ready[g] = 1'b1;
    tests++;
    if (bus.req_ready !== exp_ready) begin
      fails++;
      $display("[TB] FAIL req_ready cyc=%0d got=%b want=%b", cyc, bus.req_ready, exp_ready);
    end
    for (int i = 0; i < N; i++) begin
      if (bus.req_valid[i] && bus.req_ready[i]) begin
        exp_t e;
        e.z = pz[i];
        e.id = IW'(i);
        e.acc = cyc;
        e.lat = (inflight == 0);
        sb.push_back(e);
        n_acc++;
        model_last = i;
        pend[i] = 0;
      end
    end
  endtask

  // One cycle per iteration: p_req is the chance (percent) an idle requester
  // raises a new random request, p_ready the chance rsp_ready is high.
  task automatic applyStimulus(input int cycles, input int p_req, input int p_ready);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      bus.rsp_ready = ($urandom_range(99) < p_ready);
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(99) < p_req) begin
          pa[i] = rand_float();
          pb[i] = rand_float();
          pz[i] = ref_mul(pa[i], pb[i]);
          pend[i] = 1;
        end
      end
      driveBus();
      #1;
      checkOutput();
    end
  endtask

  task automatic sendOne(input int idx, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] z);
    pa[idx] = a;
    pb[idx] = b;
    pz[idx] = z;
    pend[idx] = 1;
    applyStimulus(4, 0, 100);
  endtask

  task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic startReset();
    rst = 1;
    in_reset = 1;
    bus.rsp_ready = 0;
    sb.delete();
    n_acc = 0;
    n_cons = 0;
    model_last = N - 1;
    stall_hold = 0;
    head_seen = 0;
  endtask

  // Monitor: pops the scoreboard on every completed response handshake,
  // checks first-response latency and output stability under backpressure.
  always @(negedge clk) begin
    #2;
    if (!in_reset) begin
      if (stall_hold) begin
        tests++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_z !== held_z || bus.rsp_id !== held_id) begin
          fails++;
          $display("[TB] FAIL stall_hold got=%b/%h/%0d want=1/%h/%0d",
                   bus.rsp_valid, bus.rsp_z, bus.rsp_id, held_z, held_id);
        end
      end
      if (bus.rsp_valid === 1'b1) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL spurious_rsp got z=%h id=%0d want no response", bus.rsp_z, bus.rsp_id);
        end else begin
          if (!head_seen) begin
            head_seen = 1;
            if (sb[0].lat) begin
              tests++;
              if (cyc != sb[0].acc + 2) begin
                fails++;
                $display("[TB] FAIL latency got=%0d want=2", cyc - sb[0].acc);
              end
            end
          end
          if (bus.rsp_ready === 1'b1) begin
            tests++;
            if (bus.rsp_z !== sb[0].z || bus.rsp_id !== sb[0].id) begin
              fails++;
              $display("[TB] FAIL rsp got z=%h id=%0d want z=%h id=%0d",
                       bus.rsp_z, bus.rsp_id, sb[0].z, sb[0].id);
            end
            void'(sb.pop_front());
            n_cons++;
            head_seen = 0;
          end
        end
      end
      stall_hold = (bus.rsp_valid === 1'b1) && (bus.rsp_ready !== 1'b1);
      held_z = bus.rsp_z;
      held_id = bus.rsp_id;
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      pend[i] = 0;
      pa[i] = '0;
      pb[i] = '0;
      pz[i] = '0;
    end
    bus.rsp_ready = 0;
    driveBus();
    startReset();

    // Reset state
    @(negedge clk);
    #1;
    checkVal("reset_req_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    rst = 0;
    in_reset = 0;
    #1;
    checkVal("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkVal("reset_rsp_z", bus.rsp_z, 32'd0);
    checkVal("reset_rsp_id", 32'(bus.rsp_id), 32'd0);

    // Directed products
    sendOne(0, 32'h40A00000, 32'h40400000, 32'h41700000);
    sendOne(2, 32'hC0A00000, 32'h40E00000, 32'hC20C0000);
    sendOne(1, 32'h00000000, 32'h40400000, 32'h00000000);

    // Idle: no requests, nothing comes out
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1, 0, 100);
      checkVal("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    end

    // Fairness, then backpressure and release, then random traffic
    applyStimulus(12, 100, 100);
    applyStimulus(5, 100, 0);
    applyStimulus(12, 100, 100);
    applyStimulus(2000, 50, 70);

    // Reset with both stages full
    applyStimulus(4, 100, 0);
    @(negedge clk);
    startReset();
    driveBus();
    #1;
    checkVal("midreset_req_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    rst = 0;
    in_reset = 0;
    #1;
    checkVal("midreset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkVal("midreset_rsp_z", bus.rsp_z, 32'd0);
    checkVal("midreset_rsp_id", 32'(bus.rsp_id), 32'd0);
    checkOutput();
    applyStimulus(20, 100, 100);

    // Drain and confirm nothing was lost
    applyStimulus(10, 0, 100);
    checkVal("drain_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
